// File: rtl/trig_capture_cache_if.sv
// Signal bundle between the ADC/MCU side and trig_capture_cache.
// master drives stimulus and control, slave is the capture cache itself.
interface trig_capture_cache_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
);
    logic              samp_clk;
    logic              cs_n;
    logic [DATA_W-1:0] ad_in;
    logic              arm;
    logic              force_trig;
    logic [DATA_W-1:0] trig_level;
    logic              trig_rising;
    logic [ADDR_W-1:0] pre_len;
    logic [DATA_W-1:0] ad_out;
    logic              busy;
    logic              done;
    logic              trig_auto;

    modport master (
        output samp_clk, cs_n, ad_in, arm, force_trig, trig_level, trig_rising, pre_len,
        input  ad_out, busy, done, trig_auto
    );

    modport slave (
        input  samp_clk, cs_n, ad_in, arm, force_trig, trig_level, trig_rising, pre_len,
        output ad_out, busy, done, trig_auto
    );
endinterface

// File: rtl/trig_capture_cache.sv
// Triggered ADC capture cache: samples land in a 2^ADDR_W circular buffer with a
// pre-trigger window and a level/slope trigger, then the frozen buffer is read out
// oldest-first, one word per MCU cs_n falling edge.
// Optional macro AUTO_TRIG_EN: fire an auto trigger after AUTO_TIMEOUT armed samples.
module trig_capture_cache #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned AUTO_TIMEOUT = 4096
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    trig_capture_cache_if.slave  cap_if
);

    localparam int unsigned Depth = 1 << ADDR_W;
    localparam int unsigned CntW  = ADDR_W + 1;

    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [CntW-1:0]   cnt_t;

    typedef enum logic [2:0] {StIdle, StFill, StArmed, StPost, StDone} state_e;

    state_e            state_q, state_d;
    logic [2:0]        samp_sync_q, cs_sync_q;
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    ptr_t              trig_ptr_q, trig_ptr_d;
    ptr_t              pl_q, pl_d;
    ptr_t              fill_cnt_q, fill_cnt_d;
    cnt_t              post_cnt_q, post_cnt_d;
    cnt_t              rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic              force_pend_q, force_pend_d;
    logic [DATA_W-1:0] ad_out_q, ad_out_d;
    logic [DATA_W-1:0] mem_q [Depth];

    logic samp_pulse, rd_pulse, capturing, wr_en;
    logic rise_hit, fall_hit, level_hit, force_hit, auto_hit, trig_fire;
    cnt_t post_target;

    // s0 -> s1 -> s2; edges are taken between s1 and s2
    assign samp_pulse = samp_sync_q[1] & ~samp_sync_q[2];
    assign rd_pulse   = ~cs_sync_q[1] & cs_sync_q[2];

    assign capturing = (state_q == StFill) || (state_q == StArmed) || (state_q == StPost);
    // arm restarts the capture, so a coincident sample is dropped
    assign wr_en     = capturing & samp_pulse & ~cap_if.arm;

    assign rise_hit  = prev_valid_q && (prev_q < cap_if.trig_level) &&
                       (cap_if.ad_in >= cap_if.trig_level);
    assign fall_hit  = prev_valid_q && (prev_q > cap_if.trig_level) &&
                       (cap_if.ad_in <= cap_if.trig_level);
    assign level_hit = cap_if.trig_rising ? rise_hit : fall_hit;
    assign force_hit = force_pend_q | cap_if.force_trig;
    assign trig_fire = (state_q == StArmed) && wr_en && (level_hit || force_hit || auto_hit);

    // Post-trigger samples, trigger sample included
    assign post_target = cnt_t'(Depth) - cnt_t'(pl_q);

    // Next-state and datapath updates for the capture/readout FSM
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        trig_ptr_d   = trig_ptr_q;
        pl_d         = pl_q;
        fill_cnt_d   = fill_cnt_q;
        post_cnt_d   = post_cnt_q;
        rd_cnt_d     = rd_cnt_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        force_pend_d = force_pend_q;
        ad_out_d     = ad_out_q;

        if (cap_if.arm) begin
            // pre_len is ADDR_W wide, so it never exceeds Depth-1
            pl_d         = cap_if.pre_len;
            state_d      = (cap_if.pre_len == '0) ? StArmed : StFill;
            fill_cnt_d   = '0;
            post_cnt_d   = '0;
            rd_cnt_d     = '0;
            prev_valid_d = 1'b0;
            force_pend_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d     = wr_ptr_q + 1'b1;
                prev_d       = cap_if.ad_in;
                prev_valid_d = 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                end
                StFill: begin
                    if (wr_en) begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                        if (fill_cnt_d == pl_q) begin
                            state_d = StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (cap_if.force_trig) begin
                        force_pend_d = 1'b1;
                    end
                    if (trig_fire) begin
                        trig_ptr_d   = wr_ptr_q;
                        post_cnt_d   = cnt_t'(1);
                        force_pend_d = 1'b0;
                        // With a full pre-trigger window the trigger sample completes it
                        state_d      = (post_target == cnt_t'(1)) ? StDone : StPost;
                    end
                end
                StPost: begin
                    if (wr_en) begin
                        post_cnt_d = post_cnt_q + 1'b1;
                        if (post_cnt_d == post_target) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (rd_pulse) begin
                        ad_out_d = mem_q[rd_ptr_q];
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        if (rd_cnt_q == cnt_t'(Depth - 1)) begin
                            state_d = StIdle;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase

            // Oldest sample of the frozen window sits pl words before the trigger
            if ((state_d == StDone) && (state_q != StDone)) begin
                rd_ptr_d = trig_ptr_d - pl_q;
                rd_cnt_d = '0;
            end
        end
    end

    // State, synchroniser and datapath registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            samp_sync_q  <= '1;
            cs_sync_q    <= '1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            trig_ptr_q   <= '0;
            pl_q         <= '0;
            fill_cnt_q   <= '0;
            post_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            force_pend_q <= 1'b0;
            ad_out_q     <= '0;
        end else begin
            state_q      <= state_d;
            samp_sync_q  <= {samp_sync_q[1:0], cap_if.samp_clk};
            cs_sync_q    <= {cs_sync_q[1:0], cap_if.cs_n};
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            trig_ptr_q   <= trig_ptr_d;
            pl_q         <= pl_d;
            fill_cnt_q   <= fill_cnt_d;
            post_cnt_q   <= post_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            force_pend_q <= force_pend_d;
            ad_out_q     <= ad_out_d;
        end
    end

    // Sample buffer, inferred RAM without reset
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= cap_if.ad_in;
        end
    end

`ifdef AUTO_TRIG_EN
    localparam int unsigned AutoW = $clog2(AUTO_TIMEOUT + 1);

    logic [AutoW-1:0] auto_cnt_q, auto_cnt_d;
    logic             trig_auto_q, trig_auto_d;

    assign auto_hit = (state_q == StArmed) && (auto_cnt_q == AutoW'(AUTO_TIMEOUT));

    // Armed-sample counter and auto-trigger flag
    always_comb begin
        auto_cnt_d  = auto_cnt_q;
        trig_auto_d = trig_auto_q;
        if (cap_if.arm) begin
            auto_cnt_d  = '0;
            trig_auto_d = 1'b0;
        end else begin
            if (trig_fire) begin
                trig_auto_d = auto_hit & ~level_hit & ~force_hit;
            end
            if (state_d != state_q) begin
                auto_cnt_d = '0;
            end else if ((state_q == StArmed) && wr_en) begin
                auto_cnt_d = auto_cnt_q + 1'b1;
            end
        end
    end

    // Auto-trigger registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            auto_cnt_q  <= '0;
            trig_auto_q <= 1'b0;
        end else begin
            auto_cnt_q  <= auto_cnt_d;
            trig_auto_q <= trig_auto_d;
        end
    end

    assign cap_if.trig_auto = trig_auto_q;
`else
    logic unused_auto_timeout;

    assign auto_hit            = 1'b0;
    assign unused_auto_timeout = ^AUTO_TIMEOUT;
    assign cap_if.trig_auto    = 1'b0;
`endif

    assign cap_if.ad_out = ad_out_q;
    assign cap_if.busy   = capturing;
    assign cap_if.done   = (state_q == StDone);

endmodule

// File: tb/tb_trig_capture_cache.sv
// Randomised bench for trig_capture_cache: a sample-list model decides which
// sample triggers, when the capture ends and which window the MCU reads back.
module tb_trig_capture_cache;

    localparam int unsigned DataW  = 8;
    localparam int unsigned AddrW  = 4;
    localparam int          Depth  = 16;
    localparam int unsigned AutoTo = 8;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;

    trig_capture_cache_if #(.DATA_W(DataW), .ADDR_W(AddrW)) cap_if ();

    trig_capture_cache #(
        .DATA_W       (DataW),
        .ADDR_W       (AddrW),
        .AUTO_TIMEOUT (AutoTo)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .cap_if  (cap_if.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: every sample accepted since arm, in order
    int m_samp[$];
    int m_pl, m_trig, m_rd_idx, m_ad_out, m_level;
    bit m_rising, m_force, m_auto, m_done, m_cap;

    function automatic void model_write(input int v);
        int  k;
        bit  hit;
        k = m_samp.size();
        m_samp.push_back(v);
        if (m_trig < 0 && k >= m_pl) begin
            hit = m_force;
            if (k >= 1) begin
                if (m_rising) hit = hit | (m_samp[k-1] < m_level && v >= m_level);
                else          hit = hit | (m_samp[k-1] > m_level && v <= m_level);
            end
`ifdef AUTO_TRIG_EN
            if (!hit && (k - m_pl) == int'(AutoTo)) begin
                hit    = 1'b1;
                m_auto = 1'b1;
            end
`endif
            if (hit) begin
                m_trig  = k;
                m_force = 1'b0;
            end
        end
        // Window is pl samples before the trigger plus Depth-pl from it onwards
        if (m_trig >= 0 && k == m_trig + Depth - m_pl - 1) begin
            m_done   = 1'b1;
            m_cap    = 1'b0;
            m_rd_idx = 0;
        end
    endfunction

    function automatic int gen(input int kind, input int base, input int i);
        case (kind)
            1:       return (base + i) & 8'hff;
            2:       return (base - i) & 8'hff;
            3:       return base;
            default: return int'($urandom_range(255, 0));
        endcase
    endfunction

    task automatic set_trig(input int lvl, input bit rising);
        cap_if.trig_level  = lvl[DataW-1:0];
        cap_if.trig_rising = rising;
        m_level            = lvl;
        m_rising           = rising;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge sys_clk);
        m_cap = 0; m_done = 0; m_auto = 0; m_ad_out = 0;
        check_eq("rst_busy", cap_if.busy, 0);
        check_eq("rst_done", cap_if.done, 0);
        check_eq("rst_ad_out", cap_if.ad_out, 0);
        check_eq("rst_trig_auto", cap_if.trig_auto, 0);
        rst = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic do_arm(input int pl);
        cap_if.pre_len = pl[AddrW-1:0];
        cap_if.arm     = 1'b1;
        @(negedge sys_clk);
        cap_if.arm = 1'b0;
        @(negedge sys_clk);
        m_samp.delete();
        m_pl = pl; m_trig = -1; m_force = 0; m_auto = 0; m_done = 0; m_cap = 1; m_rd_idx = 0;
        check_eq("arm_busy_done", {cap_if.busy, cap_if.done}, 2'b10);
    endtask

    task automatic send_sample(input int v);
        cap_if.ad_in    = v[DataW-1:0];
        cap_if.samp_clk = 1'b1;
        repeat (4) @(negedge sys_clk);
        cap_if.samp_clk = 1'b0;
        repeat (4) @(negedge sys_clk);
        if (m_cap) model_write(v);
        check_eq("samp_busy_done", {cap_if.busy, cap_if.done}, {m_cap, m_done});
    endtask

    task automatic pulse_force();
        cap_if.force_trig = 1'b1;
        @(negedge sys_clk);
        cap_if.force_trig = 1'b0;
        @(negedge sys_clk);
        if (m_cap && m_trig < 0 && m_samp.size() >= m_pl) m_force = 1'b1;
    endtask

    task automatic read_word();
        cap_if.cs_n = 1'b0;
        repeat (4) @(negedge sys_clk);
        cap_if.cs_n = 1'b1;
        repeat (4) @(negedge sys_clk);
        if (m_done) begin
            m_ad_out = m_samp[m_trig - m_pl + m_rd_idx];
            m_rd_idx++;
            if (m_rd_idx == Depth) m_done = 1'b0;
        end
        check_eq("rd_ad_out", cap_if.ad_out, m_ad_out);
        check_eq("rd_done", cap_if.done, m_done);
    endtask

    task automatic read_n(input int n);
        for (int i = 0; i < n; i++) read_word();
    endtask

    task automatic run_capture(input int kind, input int base, input int force_after,
                               input int limit);
        for (int i = 0; i < limit && m_cap; i++) begin
            if (force_after >= 0 && m_trig < 0 && m_samp.size() == m_pl + force_after)
                pulse_force();
            send_sample(gen(kind, base, i));
        end
    endtask

    initial begin
        cap_if.samp_clk    = 1'b0;
        cap_if.cs_n        = 1'b1;
        cap_if.ad_in       = '0;
        cap_if.arm         = 1'b0;
        cap_if.force_trig  = 1'b0;
        cap_if.trig_level  = '0;
        cap_if.trig_rising = 1'b1;
        cap_if.pre_len     = '0;
        repeat (3) @(negedge sys_clk);
        do_reset();

        // Rising ramp, reads strobed during FILL and ARMED must be ignored
        set_trig(8'h20, 1'b1);
        do_arm(4);
        send_sample(8'h00);
        send_sample(8'h01);
        read_word();
        for (int v = 2; v < 6; v++) send_sample(v);
        read_word();
        run_capture(1, 6, -1, 300);
        read_n(Depth);

        // Falling ramp from 0xFF
        set_trig(8'h20, 1'b0);
        do_arm(4);
        run_capture(2, 8'hff, -1, 300);
        read_n(Depth);

        // No pre-trigger window, forced trigger on a constant input
        set_trig(8'h80, 1'b1);
        do_arm(0);
        run_capture(3, 8'h55, 3, 300);
        read_n(Depth);

        // Force in FILL is ignored; re-arm in DONE after a partial readout
        set_trig(int'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
        do_arm(int'($urandom_range(15, 1)));
        pulse_force();
        run_capture(0, 0, 30, 300);
        read_n(5);
        do_arm(6);
        run_capture(0, 0, 30, 300);
        read_n(Depth);

        // Reset in the middle of POST
        set_trig(8'h20, 1'b1);
        do_arm(2);
        for (int i = 0; i < 64 && m_cap && m_trig < 0; i++) send_sample(8'h10 + i);
        do_reset();

        // Randomised captures, first one with the largest pre-trigger window
        for (int t = 0; t < 8; t++) begin
            set_trig(int'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
            do_arm((t == 0) ? 15 : int'($urandom_range(15, 0)));
            run_capture(0, 0, int'($urandom_range(20, 0)), 300);
            check_eq("trig_auto", cap_if.trig_auto, m_auto);
            read_n(Depth);
        end

        // Constant input below the level: only an auto trigger can end it
        set_trig(8'h80, 1'b1);
        do_arm(0);
        run_capture(3, 8'h10, -1, 100);
        check_eq("auto_trig_auto", cap_if.trig_auto, m_auto);
        check_eq("auto_done", cap_if.done, m_done);
        if (m_done) read_n(Depth);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
